// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle logic/arith ops plus 32-step shift-add multiply
module alu_mc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t      state_q;
  logic [31:0] result_q;
  logic        done_q;
  logic        busy_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;
  logic [31:0] single_res;
  logic [31:0] acc_step;

  // Signed compare is done directly rather than via the sign of the difference,
  // so SLT stays correct when src1 - src2 overflows.
  always_comb begin
    single_res = 32'd0;
    case (ctrl_i)
      OP_AND:  single_res = src1_i & src2_i;
      OP_OR:   single_res = src1_i | src2_i;
      OP_ADD:  single_res = src1_i + src2_i;
      OP_SUB:  single_res = src1_i - src2_i;
      OP_SLT:  single_res = ($signed(src1_i) < $signed(src2_i)) ? 32'd1 : 32'd0;
      default: single_res = 32'd0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (ctrl_i == OP_MUL) begin
              mcand_q  <= src1_i;
              mplier_q <= src2_i;
              acc_q    <= 32'd0;
              cnt_q    <= 5'd0;
              busy_q   <= 1'b1;
              state_q  <= MUL;
            end else begin
              result_q <= single_res;
              done_q   <= 1'b1;
            end
          end
        end
        MUL: begin
          // Only the low word is kept, so the multiplicand may shift out the top.
          acc_q    <= acc_step;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= acc_step;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign zero_o   = (result_q == 32'd0);
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  alu_mc dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .ctrl_i   (ctrl),
    .src1_i   (src1),
    .src2_i   (src2),
    .result_o (result),
    .zero_o   (zero),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    ctrl  = c;
    src1  = a;
    src2  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ctrl = 4'd0; src1 = 32'd0; src2 = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got result=%h done=%b busy=%b zero=%b, want 0 0 0 1", result, done, busy, zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_add;
    run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001);
    checks++;
    if (done !== 1'b1 || result !== 32'h80000000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap: got done=%b result=%h zero=%b, want 1 80000000 0", done, result, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== 32'h80000000) begin
      errors++;
      $display("FAIL add_pulse_hold: got done=%b result=%h, want 0 80000000", done, result);
    end
    run_op(4'b0010, 32'hFFFFFFFF, 32'h00000002);
    checks++;
    if (result !== 32'h00000001) begin
      errors++;
      $display("FAIL add_carry_out: got %h, want 00000001", result);
    end
  endtask

  task automatic test_sub_slt;
    run_op(4'b0110, 32'd5, 32'd5);
    checks++;
    if (done !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: got done=%b result=%h zero=%b, want 1 0 1", done, result, zero);
    end
    run_op(4'b0110, 32'd3, 32'd5);
    checks++;
    if (result !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL sub_negative: got %h, want fffffffe", result);
    end
    run_op(4'b0111, 32'h80000000, 32'h00000001);
    checks++;
    if (done !== 1'b1 || result !== 32'd1) begin
      errors++;
      $display("FAIL slt_minint: got done=%b result=%h, want 1 1", done, result);
    end
    run_op(4'b0111, 32'h7FFFFFFF, 32'h80000000);
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL slt_overflow: got %h, want 0", result);
    end
    run_op(4'b0111, 32'd5, 32'd5);
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL slt_equal: got %h, want 0", result);
    end
    run_op(4'b0111, 32'hFFFFFFFF, 32'h7FFFFFFF);
    checks++;
    if (result !== 32'd1) begin
      errors++;
      $display("FAIL slt_neg_vs_pos: got %h, want 1", result);
    end
  endtask

  task automatic test_mul;
    int cycles;
    int busy_bad;
    int hold_bad;
    run_op(4'b1000, 32'h0000FFFF, 32'h00010001);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd1) begin
      errors++;
      $display("FAIL mul_enter: got busy=%b done=%b result=%h, want 1 0 1", busy, done, result);
    end
    cycles = 0; busy_bad = 0; hold_bad = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy !== 1'b1) busy_bad++;
      if (result !== 32'd1) hold_bad++;
      if (cycles == 16) begin
        ctrl = 4'b0010; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (cycles !== 32) begin
      errors++;
      $display("FAIL mul_latency: got %0d cycles, want 32", cycles);
    end
    checks++;
    if (busy_bad !== 0 || hold_bad !== 0) begin
      errors++;
      $display("FAIL mul_busy_hold: got busy_low=%0d result_changed=%0d, want 0 0", busy_bad, hold_bad);
    end
    checks++;
    if (result !== 32'hFFFFFFFF || busy !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: got result=%h busy=%b zero=%b, want ffffffff 0 0", result, busy, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mul_no_queue: got done=%b busy=%b result=%h, want 0 0 ffffffff", done, busy, result);
    end
  endtask

  task automatic test_back_to_back;
    int cycles;
    run_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cycles = 1;
    while (done !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    if (done !== 1'b1 || result !== 32'h00000001) begin
      errors++;
      $display("FAIL mul_neg_result: got done=%b result=%h, want 1 00000001", done, result);
    end
    ctrl = 4'b0000; src1 = 32'hF0F0F0F0; src2 = 32'h0FF00FF0; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 32'h00F000F0) begin
      errors++;
      $display("FAIL and_after_done: got done=%b busy=%b result=%h, want 1 0 00f000f0", done, busy, result);
    end
    ctrl = 4'b0010; src1 = 32'd2; src2 = 32'd3;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || result !== 32'd5) begin
      errors++;
      $display("FAIL add_back_to_back: got done=%b result=%h, want 1 5", done, result);
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || result !== 32'd5) begin
      errors++;
      $display("FAIL b2b_idle: got done=%b result=%h, want 0 5", done, result);
    end
  endtask

  task automatic test_reset_mid_mul;
    int dones;
    run_op(4'b1000, 32'h0000FFFF, 32'h00010001);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mul: got result=%h done=%b busy=%b zero=%b, want 0 0 0 1", result, done, busy, zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d cycles with done/busy, want 0", dones);
    end
    run_op(4'b0001, 32'h1, 32'h2);
    checks++;
    if (done !== 1'b1 || result !== 32'h3 || zero !== 1'b0) begin
      errors++;
      $display("FAIL or_after_reset: got done=%b result=%h zero=%b, want 1 3 0", done, result, zero);
    end
  endtask

  task automatic test_undefined;
    run_op(4'b0101, 32'hDEADBEEF, 32'h12345678);
    checks++;
    if (done !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL undef_0101: got done=%b result=%h zero=%b, want 1 0 1", done, result, zero);
    end
    run_op(4'b0001, 32'h10, 32'h01);
    run_op(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (done !== 1'b1 || result !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL undef_1111: got done=%b result=%h busy=%b, want 1 0 0", done, result, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_undefined();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named as below.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 start_i  input  1  request strobe; sampled only in IDLE.
REQ-005 ctrl_i  input  4  operation code as produced by the ALU controller: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MUL.
REQ-006 src1_i  input  32  operand A; sampled with start_i.
REQ-007 src2_i  input  32  operand B; sampled with start_i.
REQ-008 result_o  output  32  registered result; holds its value until the next completion.
REQ-009 zero_o  output  1  high when result_o == 0; derived from result_o only.
REQ-010 busy_o  output  1  high while the FSM is in MUL.
REQ-011 done_o  output  1  registered one-cycle completion pulse.

Function
REQ-012 FSM states SHALL be IDLE and MUL; reset state is IDLE.
REQ-013 In IDLE with start_i=1 and ctrl_i != 1000, the block SHALL register the result and assert done_o on the next edge: latency 1 cycle.
REQ-014 AND/OR SHALL be bitwise on src1_i and src2_i.
REQ-015 ADD/SUB SHALL wrap modulo 2^32, with no overflow flag.
REQ-016 SLT SHALL return 32'd1 if signed src1_i < signed src2_i, else 32'd0, and SHALL be correct when src1_i - src2_i overflows.
REQ-017 Any undefined ctrl_i code SHALL complete in 1 cycle with result_o = 0.
REQ-018 In IDLE with start_i=1 and ctrl_i=1000, the block SHALL latch both operands, clear the accumulator and the 5-bit iteration counter, and enter MUL.
REQ-019 Each MUL cycle SHALL perform one shift-add step: if multiplier bit0=1, add the multiplicand to the accumulator; then shift the multiplicand left 1 and the multiplier right 1; counter +1.
REQ-020 On the 32nd MUL edge (counter == 31), the block SHALL write the low 32 bits of the product to result_o, pulse done_o, and return to IDLE: latency 32 cycles after the start edge.
REQ-021 The low-32 product is identical for signed and unsigned operands; no high word SHALL be produced.
REQ-022 start_i while busy_o=1 SHALL be ignored; it is neither queued nor allowed to disturb operands.
REQ-023 done_o SHALL be high for exactly one cycle per accepted start_i and never otherwise.
REQ-024 A start_i in the IDLE cycle that coincides with done_o high SHALL be accepted, giving back-to-back single-cycle ops one per clock.
REQ-025 result_o SHALL be updated only on completion; it holds its previous value during MUL.

Reset
REQ-026 Asserting rst_i SHALL immediately force IDLE and set result_o=0, done_o=0, busy_o=0, counter=0, accumulator=0 (zero_o consequently 1).
REQ-027 Reset asserted mid-MUL SHALL abort the operation with no done_o pulse; the first start_i after rst_i is released SHALL behave as from power-up.

Verification
REQ-028 ADD 0x7FFFFFFF + 0x00000001, start 1 cycle -> next cycle done_o=1, result_o=0x80000000, zero_o=0.
REQ-029 SUB 5 - 5 -> result_o=0, zero_o=1, done_o pulse 1 cycle later; then SLT 0x80000000 vs 0x00000001 -> result_o=1.
REQ-030 MUL 0x0000FFFF x 0x00010001 -> busy_o=1 for 32 cycles, done_o on cycle 32, result_o=0xFFFFFFFF; start_i pulsed mid-MUL has no effect.
REQ-031 MUL 0xFFFFFFFF x 0xFFFFFFFF -> result_o=0x00000001; AND 0xF0F0F0F0 & 0x0FF00FF0 issued same cycle as done_o -> next cycle result_o=0x00F000F0.
REQ-032 rst_i asserted at MUL iteration 10 -> outputs zero immediately, no done_o; subsequent OR 0x1 | 0x2 -> result_o=0x3 after 1 cycle.
REQ-033 ctrl_i=0101 (undefined) -> done_o after 1 cycle, result_o=0, zero_o=1.
